// File: rtl/outbuf_drain_if.sv
// Handshake and status bundle between a PE column drain buffer and its consumer.
interface outbuf_drain_if #(
  parameter int unsigned WORDLEN = 8
) ();
  logic               in_valid;
  logic [WORDLEN-1:0] din;
  logic               full;
  logic               empty;
  logic [5:0]         count;
  logic               out_valid;
  logic               out_ready;
  logic [WORDLEN-1:0] dout;
  logic               overflow;
  logic               skipping;

  // Buffer side: takes column words and consumer ready, drives head word and status.
  modport slave (
    input  in_valid, din, out_ready,
    output full, empty, count, out_valid, dout, overflow, skipping
  );

  // Environment side: PE column plus downstream consumer.
  modport master (
    output in_valid, din, out_ready,
    input  full, empty, count, out_valid, dout, overflow, skipping
  );
endinterface

// File: rtl/outbuf_drain.sv
// Drain-side result FIFO for one systolic column: discards the leading fill
// words after reset, then buffers results and hands them out first-word
// fall-through over valid/ready. Overflow drops are sticky until reset.
module outbuf_drain #(
  parameter int unsigned WORDLEN = 8,
  parameter int unsigned BUFSIZE = 10,
  parameter int unsigned SKIP    = 0
) (
  input  logic          clk,
  input  logic          rst,
  outbuf_drain_if.slave bus
);

  localparam int unsigned AW    = (BUFSIZE <= 2) ? 1 : $clog2(BUFSIZE);
  localparam int unsigned CNTW  = 6;
  localparam int unsigned SKIPW = 5;

  logic [WORDLEN-1:0] mem [BUFSIZE];
  logic [AW-1:0]      head;
  logic [AW-1:0]      tail;
  logic [CNTW-1:0]    cnt;
  logic [SKIPW-1:0]   skip_cnt;
  logic               ovf;

  logic full_c;
  logic empty_c;
  logic skip_active_c;
  logic pop_c;
  logic push_c;
  logic drop_c;
  logic [AW-1:0] head_nxt_c;
  logic [AW-1:0] tail_nxt_c;

  // Handshake decode from current occupancy and skip state.
  always_comb begin
    full_c        = (cnt == CNTW'(BUFSIZE));
    empty_c       = (cnt == '0);
    skip_active_c = (skip_cnt != '0);
    pop_c         = !empty_c && bus.out_ready;
    push_c        = bus.in_valid && !skip_active_c && (!full_c || pop_c);
    drop_c        = bus.in_valid && !skip_active_c && full_c && !pop_c;
    head_nxt_c    = (head == AW'(BUFSIZE - 1)) ? '0 : head + AW'(1);
    tail_nxt_c    = (tail == AW'(BUFSIZE - 1)) ? '0 : tail + AW'(1);
  end

  // Pointer, occupancy, skip counter and sticky overflow state.
  always_ff @(posedge clk) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
      skip_cnt <= SKIPW'(SKIP);
    end else begin
      if (pop_c) begin
        head <= head_nxt_c;
      end
      if (push_c) begin
        tail <= tail_nxt_c;
      end
      case ({push_c, pop_c})
        2'b10:   cnt <= cnt + CNTW'(1);
        2'b01:   cnt <= cnt - CNTW'(1);
        default: cnt <= cnt;
      endcase
      if (bus.in_valid && skip_active_c) begin
        skip_cnt <= skip_cnt - SKIPW'(1);
      end
      if (drop_c) begin
        ovf <= 1'b1;
      end
    end
  end

  // Word storage; contents are left untouched by reset.
  always_ff @(posedge clk) begin
    if (push_c && !rst) begin
      mem[tail] <= bus.din;
    end
  end

  assign bus.full      = full_c;
  assign bus.empty     = empty_c;
  assign bus.count     = cnt;
  assign bus.out_valid = !empty_c;
  assign bus.dout      = empty_c ? '0 : mem[head];
  assign bus.overflow  = ovf;
  assign bus.skipping  = skip_active_c;

endmodule

// File: tb/tb_outbuf_drain.sv
// Bench for outbuf_drain: table of directed vectors, hand sequences for
// full/wrap/reset corners, then random traffic against a queue model.
module tb_outbuf_drain;

  localparam int unsigned WL   = 8;
  localparam int unsigned BUFS = 4;
  localparam int unsigned SKP  = 3;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  outbuf_drain_if #(.WORDLEN(WL)) bus ();

  outbuf_drain #(.WORDLEN(WL), .BUFSIZE(BUFS), .SKIP(SKP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain queue of accepted words plus skip budget and sticky flag.
  logic [WL-1:0] mq[$];
  int            msk;
  logic          movf;

  typedef struct {
    logic          r;
    logic          iv;
    logic [WL-1:0] d;
    logic          rdy;
    int            ecnt;
    logic [WL-1:0] edout;
    logic          eovf;
    logic          eskip;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    int sz;
    sz = mq.size();
    chk("count", int'(bus.count), sz);
    chk("empty", int'(bus.empty), int'(sz == 0));
    chk("full", int'(bus.full), int'(sz == int'(BUFS)));
    chk("out_valid", int'(bus.out_valid), int'(sz != 0));
    chk("dout", int'(bus.dout), (sz == 0) ? 0 : int'(mq[0]));
    chk("overflow", int'(bus.overflow), int'(movf));
    chk("skipping", int'(bus.skipping), int'(msk != 0));
  endtask

  // One clock: drive inputs, advance the model, sample after the edge.
  task automatic cyc(input logic r, input logic iv, input logic [WL-1:0] d, input logic rdy);
    bit pop;
    rst           = r;
    bus.in_valid  = iv;
    bus.din       = d;
    bus.out_ready = rdy;
    pop = (mq.size() > 0) && rdy;
    if (r) begin
      mq.delete();
      msk  = int'(SKP);
      movf = 1'b0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (iv) begin
        if (msk > 0) msk--;
        else if (mq.size() < int'(BUFS)) mq.push_back(d);
        else movf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic add(input logic r, input logic iv, input logic [WL-1:0] d, input logic rdy,
                     input int ecnt, input logic [WL-1:0] edout, input logic eovf,
                     input logic eskip);
    vec_t v;
    v.r = r; v.iv = iv; v.d = d; v.rdy = rdy;
    v.ecnt = ecnt; v.edout = edout; v.eovf = eovf; v.eskip = eskip;
    tbl.push_back(v);
  endtask

  task automatic reset_and_skip();
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < int'(SKP); i++) cyc(1'b0, 1'b1, 8'hEE, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    msk    = int'(SKP);
    movf   = 1'b0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.din       = '0;
    bus.out_ready = 1'b0;

    //   rst iv  din    rdy  cnt dout   ovf  skip
    add(1, 0, 8'h00, 0, 0, 8'h00, 0, 1);
    add(0, 1, 8'hA0, 0, 0, 8'h00, 0, 1);
    add(0, 1, 8'hA1, 0, 0, 8'h00, 0, 1);
    add(0, 0, 8'h00, 0, 0, 8'h00, 0, 1);
    add(0, 1, 8'hA2, 0, 0, 8'h00, 0, 0);
    add(0, 1, 8'hA3, 0, 1, 8'hA3, 0, 0);
    add(0, 1, 8'hA4, 0, 2, 8'hA3, 0, 0);
    add(0, 1, 8'hA5, 0, 3, 8'hA3, 0, 0);
    add(0, 0, 8'h00, 1, 2, 8'hA4, 0, 0);
    add(0, 0, 8'h00, 1, 1, 8'hA5, 0, 0);
    add(0, 0, 8'h00, 1, 0, 8'h00, 0, 0);
    add(0, 0, 8'h00, 1, 0, 8'h00, 0, 0);
    add(0, 1, 8'h11, 0, 1, 8'h11, 0, 0);
    add(0, 1, 8'h22, 0, 2, 8'h11, 0, 0);
    add(0, 1, 8'h33, 0, 3, 8'h11, 0, 0);
    add(0, 1, 8'h44, 0, 4, 8'h11, 0, 0);
    add(0, 1, 8'h55, 0, 4, 8'h11, 1, 0);
    add(0, 1, 8'h99, 1, 4, 8'h22, 1, 0);
    add(0, 0, 8'h00, 1, 3, 8'h33, 1, 0);
    add(0, 0, 8'h00, 1, 2, 8'h44, 1, 0);
    add(0, 0, 8'h00, 1, 1, 8'h99, 1, 0);
    add(0, 0, 8'h00, 1, 0, 8'h00, 1, 0);

    foreach (tbl[i]) begin
      cyc(tbl[i].r, tbl[i].iv, tbl[i].d, tbl[i].rdy);
      chk($sformatf("vec%0d.count", i), int'(bus.count), tbl[i].ecnt);
      chk($sformatf("vec%0d.dout", i), int'(bus.dout), int'(tbl[i].edout));
      chk($sformatf("vec%0d.overflow", i), int'(bus.overflow), int'(tbl[i].eovf));
      chk($sformatf("vec%0d.skipping", i), int'(bus.skipping), int'(tbl[i].eskip));
      chk($sformatf("vec%0d.empty", i), int'(bus.empty), int'(tbl[i].ecnt == 0));
      chk($sformatf("vec%0d.full", i), int'(bus.full), int'(tbl[i].ecnt == int'(BUFS)));
    end

    // Full FIFO with simultaneous push and pop keeps occupancy and raises no overflow.
    reset_and_skip();
    for (int i = 0; i < int'(BUFS); i++) cyc(1'b0, 1'b1, 8'(8'h61 + i), 1'b0);
    chk("full_before_swap", int'(bus.full), 1);
    cyc(1'b0, 1'b1, 8'h99, 1'b1);
    chk("swap.count", int'(bus.count), int'(BUFS));
    chk("swap.dout", int'(bus.dout), 8'h62);
    chk("swap.overflow", int'(bus.overflow), 0);

    // Continuous one-word-per-cycle streaming across pointer wrap.
    reset_and_skip();
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b1, 8'(i), 1'b1);
      chk("wrap.dout", int'(bus.dout), i);
      chk("wrap.count", int'(bus.count), 1);
    end
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("wrap.empty_after", int'(bus.empty), 1);
    chk("wrap.overflow", int'(bus.overflow), 0);

    // Reset mid-drain with three words held and overflow set.
    reset_and_skip();
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 8'(8'hC0 + i), 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    chk("pre_rst.count", int'(bus.count), 3);
    chk("pre_rst.overflow", int'(bus.overflow), 1);
    cyc(1'b1, 1'b1, 8'h77, 1'b1);
    chk("rst.count", int'(bus.count), 0);
    chk("rst.empty", int'(bus.empty), 1);
    chk("rst.dout", int'(bus.dout), 0);
    chk("rst.overflow", int'(bus.overflow), 0);
    chk("rst.skipping", int'(bus.skipping), 1);

    // Random traffic with varying consumer pressure and occasional resets.
    for (int n = 0; n < 1200; n++) begin
      logic r;
      logic iv;
      logic rdy;
      r   = ($urandom_range(0, 79) == 0);
      iv  = ($urandom_range(0, 3) != 0);
      rdy = (n < 600) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
      cyc(r, iv, 8'($urandom), rdy);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
